if_de_fetch_stage: RTL and testbench

- Fetch stage plus IF/DE pipeline register of the 5-stage RV32I pipeline.
- Owns the PC and the next-PC mux, and runs the variable-latency instruction-memory handshake.
- Consumes the hazard unit's load_use_haz (stall) and control_haz/pc_source (redirect + flush).
- Holds fetched instructions in a 1-entry skid buffer while Decode is stalled.

---
 rtl/if_de_fetch_stage.sv | 140 ++++++++++++++
 tb/tb_if_de_fetch_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/if_de_fetch_stage.sv
// rtl/if_de_fetch_stage.sv - RV32I fetch stage with PC, imem handshake, skid buffer and IF/DE register
// A fetched word that arrives while Decode is stalled parks in a one-entry hold buffer.
module if_de_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        load_use_haz,
  input  logic        control_haz,
  input  logic [1:0]  pc_source,
  input  logic [31:0] jalr_target,
  input  logic [31:0] branch_target,
  input  logic [31:0] jal_target,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] de_ir,
  output logic [31:0] de_pc,
  output logic        de_valid
);

  typedef enum logic {
    RUN,
    REDIRECT_PEND
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] de_ir_n, de_pc_n;
  logic        de_valid_n;
  logic [31:0] hold_ir, hold_ir_n;
  logic [31:0] hold_pc, hold_pc_n;
  logic        hold_valid, hold_valid_n;
  logic [31:0] redir_reg, redir_reg_n;

  logic        ack;
  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign imem_req  = !RST && !hold_valid;
  assign imem_addr = pc;

  // An ack can only complete a request that is actually being presented.
  assign ack    = imem_ack && imem_req;
  assign pc_inc = pc + 32'd4;

  always_comb begin
    target_raw = pc;
    redirect   = 1'b0;
    case (pc_source)
      2'b01: begin target_raw = jalr_target;   redirect = control_haz; end
      2'b10: begin target_raw = branch_target; redirect = control_haz; end
      2'b11: begin target_raw = jal_target;    redirect = control_haz; end
      default: begin target_raw = pc;          redirect = 1'b0;        end
    endcase
    target = {target_raw[31:2], 2'b00};
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    de_ir_n      = de_ir;
    de_pc_n      = de_pc;
    de_valid_n   = de_valid;
    hold_ir_n    = hold_ir;
    hold_pc_n    = hold_pc;
    hold_valid_n = hold_valid;
    redir_reg_n  = redir_reg;

    if (redirect) begin
      de_ir_n      = NOP_INSTR;
      de_valid_n   = 1'b0;
      hold_valid_n = 1'b0;
      if (ack) begin
        pc_n    = target;
        state_n = RUN;
      end else begin
        // PC stays put so the in-flight request keeps a stable address.
        redir_reg_n = target;
        state_n     = REDIRECT_PEND;
      end
    end else if (state == REDIRECT_PEND) begin
      de_ir_n    = NOP_INSTR;
      de_valid_n = 1'b0;
      if (ack) begin
        pc_n    = redir_reg;
        state_n = RUN;
      end
    end else if (load_use_haz) begin
      if (ack) begin
        hold_ir_n    = imem_rdata;
        hold_pc_n    = pc;
        hold_valid_n = 1'b1;
        pc_n         = pc_inc;
      end
    end else if (hold_valid) begin
      de_ir_n      = hold_ir;
      de_pc_n      = hold_pc;
      de_valid_n   = 1'b1;
      hold_valid_n = 1'b0;
    end else if (ack) begin
      de_ir_n    = imem_rdata;
      de_pc_n    = pc;
      de_valid_n = 1'b1;
      pc_n       = pc_inc;
    end else begin
      de_ir_n    = NOP_INSTR;
      de_valid_n = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= RUN;
      pc         <= RESET_PC;
      de_ir      <= NOP_INSTR;
      de_pc      <= 32'd0;
      de_valid   <= 1'b0;
      hold_ir    <= NOP_INSTR;
      hold_pc    <= 32'd0;
      hold_valid <= 1'b0;
      redir_reg  <= RESET_PC;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      de_ir      <= de_ir_n;
      de_pc      <= de_pc_n;
      de_valid   <= de_valid_n;
      hold_ir    <= hold_ir_n;
      hold_pc    <= hold_pc_n;
      hold_valid <= hold_valid_n;
      redir_reg  <= redir_reg_n;
    end
  end

endmodule

// File: tb/tb_if_de_fetch_stage.sv
// tb/tb_if_de_fetch_stage.sv - directed bench for if_de_fetch_stage
// Instruction memory returns a word derived from the address unless overridden.
module tb_if_de_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK;
  logic        RST;
  logic        load_use_haz;
  logic        control_haz;
  logic [1:0]  pc_source;
  logic [31:0] jalr_target;
  logic [31:0] branch_target;
  logic [31:0] jal_target;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] de_ir;
  logic [31:0] de_pc;
  logic        de_valid;

  logic        use_ovr;
  logic [31:0] ovr_word;

  int total = 0;
  int bad   = 0;

  if_de_fetch_stage dut (
    .CLK(CLK), .RST(RST),
    .load_use_haz(load_use_haz), .control_haz(control_haz), .pc_source(pc_source),
    .jalr_target(jalr_target), .branch_target(branch_target), .jal_target(jal_target),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .imem_req(imem_req),
    .imem_addr(imem_addr), .de_ir(de_ir), .de_pc(de_pc), .de_valid(de_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h0050_0093;
    return {8'hA5, a[23:0]};
  endfunction

  assign imem_rdata = use_ovr ? ovr_word : mem_word(imem_addr);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1; imem_ack = 1'b0; load_use_haz = 1'b0; control_haz = 1'b0;
    pc_source = 2'b00; use_ovr = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1; imem_ack = 1'b1;
    tick(); tick();
    total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL reset_addr act=%h exp=%h", imem_addr, 32'd0); end
    total++; if ({de_valid, de_pc, de_ir} !== {1'b0, 32'd0, NOP}) begin bad++; $display("FAIL reset_de act=%h exp=%h", {de_valid, de_pc, de_ir}, {1'b0, 32'd0, NOP}); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req act=%b exp=0", imem_req); end
    RST = 1'b0; #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL release_req act=%b exp=1", imem_req); end
  endtask

  task automatic test_sequential;
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'h4; exp_addr[1] = 32'h8; exp_addr[2] = 32'hC;
    do_reset();
    imem_ack = 1'b1;
    total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL seq_addr0 act=%h exp=0", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({de_valid, de_pc, de_ir} !== {1'b1, exp_addr[i] - 32'd4, mem_word(exp_addr[i] - 32'd4)}) begin
        bad++; $display("FAIL seq_de%0d act=%h exp=%h", i, {de_valid, de_pc, de_ir}, {1'b1, exp_addr[i] - 32'd4, mem_word(exp_addr[i] - 32'd4)});
      end
      total++; if (imem_addr !== exp_addr[i]) begin bad++; $display("FAIL seq_addr%0d act=%h exp=%h", i + 1, imem_addr, exp_addr[i]); end
    end
  endtask

  task automatic test_wait_states;
    do_reset();
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL wait_addr%0d act=%h exp=0", i, imem_addr); end
      total++; if ({de_valid, de_ir} !== {1'b0, NOP}) begin bad++; $display("FAIL wait_de%0d act=%h exp=%h", i, {de_valid, de_ir}, {1'b0, NOP}); end
    end
    imem_ack = 1'b1;
    total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL wait_addr_ack act=%h exp=0", imem_addr); end
    tick();
    total++; if ({de_valid, de_pc, de_ir} !== {1'b1, 32'd0, 32'h0050_0093}) begin bad++; $display("FAIL wait_de_after act=%h exp=%h", {de_valid, de_pc, de_ir}, {1'b1, 32'd0, 32'h0050_0093}); end
    total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL wait_addr_after act=%h exp=4", imem_addr); end
  endtask

  task automatic test_load_use;
    do_reset();
    imem_ack = 1'b1;
    tick();
    load_use_haz = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if ({de_valid, de_pc, de_ir} !== {1'b1, 32'd0, 32'h0050_0093}) begin bad++; $display("FAIL stall_de%0d act=%h exp=%h", i, {de_valid, de_pc, de_ir}, {1'b1, 32'd0, 32'h0050_0093}); end
      total++; if ({imem_req, imem_addr} !== {1'b0, 32'h8}) begin bad++; $display("FAIL stall_req%0d act=%h exp=%h", i, {imem_req, imem_addr}, {1'b0, 32'h8}); end
    end
    load_use_haz = 1'b0;
    tick();
    total++; if ({de_valid, de_pc, de_ir} !== {1'b1, 32'h4, mem_word(32'h4)}) begin bad++; $display("FAIL unstall_de act=%h exp=%h", {de_valid, de_pc, de_ir}, {1'b1, 32'h4, mem_word(32'h4)}); end
    total++; if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin bad++; $display("FAIL unstall_req act=%h exp=%h", {imem_req, imem_addr}, {1'b1, 32'h8}); end
    tick();
    total++; if ({de_valid, de_pc, de_ir} !== {1'b1, 32'h8, mem_word(32'h8)}) begin bad++; $display("FAIL unstall_next act=%h exp=%h", {de_valid, de_pc, de_ir}, {1'b1, 32'h8, mem_word(32'h8)}); end
  endtask

  // Continues from the PC left by test_load_use (0xC).
  task automatic test_jal_flush;
    control_haz = 1'b1; pc_source = 2'b11; jal_target = 32'h100; imem_ack = 1'b1;
    tick();
    control_haz = 1'b0; pc_source = 2'b00;
    total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL jal_addr act=%h exp=100", imem_addr); end
    total++; if ({de_valid, de_ir} !== {1'b0, NOP}) begin bad++; $display("FAIL jal_flush act=%h exp=%h", {de_valid, de_ir}, {1'b0, NOP}); end
    tick();
    total++; if ({de_valid, de_pc, de_ir} !== {1'b1, 32'h100, mem_word(32'h100)}) begin bad++; $display("FAIL jal_de act=%h exp=%h", {de_valid, de_pc, de_ir}, {1'b1, 32'h100, mem_word(32'h100)}); end
  endtask

  // Continues from PC 0x104.
  task automatic test_branch_pending;
    control_haz = 1'b1; pc_source = 2'b10; branch_target = 32'h40; imem_ack = 1'b0;
    tick();
    control_haz = 1'b0; pc_source = 2'b00;
    total++; if ({imem_addr, de_valid, de_ir} !== {32'h104, 1'b0, NOP}) begin bad++; $display("FAIL br_pend0 act=%h exp=%h", {imem_addr, de_valid, de_ir}, {32'h104, 1'b0, NOP}); end
    tick();
    total++; if ({imem_addr, de_valid, de_ir} !== {32'h104, 1'b0, NOP}) begin bad++; $display("FAIL br_pend1 act=%h exp=%h", {imem_addr, de_valid, de_ir}, {32'h104, 1'b0, NOP}); end
    imem_ack = 1'b1; use_ovr = 1'b1; ovr_word = 32'hDEAD_BEEF;
    tick();
    use_ovr = 1'b0;
    total++; if ({imem_addr, de_valid, de_ir} !== {32'h40, 1'b0, NOP}) begin bad++; $display("FAIL br_discard act=%h exp=%h", {imem_addr, de_valid, de_ir}, {32'h40, 1'b0, NOP}); end
    tick();
    total++; if ({de_valid, de_pc, de_ir} !== {1'b1, 32'h40, mem_word(32'h40)}) begin bad++; $display("FAIL br_de act=%h exp=%h", {de_valid, de_pc, de_ir}, {1'b1, 32'h40, mem_word(32'h40)}); end
  endtask

  // Continues from PC 0x44.
  task automatic test_flush_beats_stall;
    load_use_haz = 1'b1; control_haz = 1'b1; pc_source = 2'b01; jalr_target = 32'h203; imem_ack = 1'b1;
    tick();
    load_use_haz = 1'b0; control_haz = 1'b0; pc_source = 2'b00;
    total++; if ({imem_req, imem_addr, de_valid} !== {1'b1, 32'h200, 1'b0}) begin bad++; $display("FAIL fbs_addr act=%h exp=%h", {imem_req, imem_addr, de_valid}, {1'b1, 32'h200, 1'b0}); end
    tick();
    total++; if ({de_valid, de_pc, de_ir} !== {1'b1, 32'h200, mem_word(32'h200)}) begin bad++; $display("FAIL fbs_de act=%h exp=%h", {de_valid, de_pc, de_ir}, {1'b1, 32'h200, mem_word(32'h200)}); end
    // Flush while a word sits in the hold buffer: the held word must be dropped.
    load_use_haz = 1'b1;
    tick();
    control_haz = 1'b1; pc_source = 2'b01; jalr_target = 32'h303; imem_ack = 1'b0;
    tick();
    load_use_haz = 1'b0; control_haz = 1'b0; pc_source = 2'b00;
    total++; if ({imem_req, imem_addr, de_valid} !== {1'b1, 32'h208, 1'b0}) begin bad++; $display("FAIL fbs_hold_clr act=%h exp=%h", {imem_req, imem_addr, de_valid}, {1'b1, 32'h208, 1'b0}); end
    imem_ack = 1'b1;
    tick();
    total++; if ({imem_addr, de_valid, de_ir} !== {32'h300, 1'b0, NOP}) begin bad++; $display("FAIL fbs_hold_redir act=%h exp=%h", {imem_addr, de_valid, de_ir}, {32'h300, 1'b0, NOP}); end
    tick();
    total++; if ({de_valid, de_pc, de_ir} !== {1'b1, 32'h300, mem_word(32'h300)}) begin bad++; $display("FAIL fbs_hold_de act=%h exp=%h", {de_valid, de_pc, de_ir}, {1'b1, 32'h300, mem_word(32'h300)}); end
  endtask

  task automatic test_wrap;
    control_haz = 1'b1; pc_source = 2'b11; jal_target = 32'hFFFF_FFFE; imem_ack = 1'b1;
    tick();
    control_haz = 1'b0; pc_source = 2'b00;
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_target act=%h exp=fffffffc", imem_addr); end
    tick();
    total++; if ({de_valid, de_pc, de_ir} !== {1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)}) begin bad++; $display("FAIL wrap_de act=%h exp=%h", {de_valid, de_pc, de_ir}, {1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)}); end
    total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL wrap_addr act=%h exp=0", imem_addr); end
  endtask

  task automatic test_reset_mid_request;
    imem_ack = 1'b0;
    tick(); tick();
    RST = 1'b1; imem_ack = 1'b1;
    tick();
    total++; if ({imem_req, imem_addr, de_valid, de_pc, de_ir} !== {1'b0, 32'd0, 1'b0, 32'd0, NOP}) begin bad++; $display("FAIL rst_mid act=%h exp=%h", {imem_req, imem_addr, de_valid, de_pc, de_ir}, {1'b0, 32'd0, 1'b0, 32'd0, NOP}); end
    RST = 1'b0;
    tick();
    total++; if ({de_valid, de_pc, de_ir} !== {1'b1, 32'd0, 32'h0050_0093}) begin bad++; $display("FAIL rst_mid_fetch act=%h exp=%h", {de_valid, de_pc, de_ir}, {1'b1, 32'd0, 32'h0050_0093}); end
  endtask

  initial begin
    RST = 1'b1; load_use_haz = 1'b0; control_haz = 1'b0; pc_source = 2'b00;
    jalr_target = 32'd0; branch_target = 32'd0; jal_target = 32'd0;
    imem_ack = 1'b0; use_ovr = 1'b0; ovr_word = 32'd0;
    test_reset();
    test_sequential();
    test_wait_states();
    test_load_use();
    test_jal_flush();
    test_branch_pending();
    test_flush_beats_stall();
    test_wrap();
    test_reset_mid_request();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
